// File: rtl/mas_mod_accum_pkg.sv
// Shared types and widths for the modular accumulator and its combinational step.
package mas_mod_accum_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned MOD_W  = 5;
    localparam int unsigned TMP_W  = 6;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] data;
    } operand_t;

endpackage

// File: rtl/mas_mod_step.sv
// One add/subtract-then-reduce step modulo q; purely combinational.
module mas_mod_step
    import mas_mod_accum_pkg::*;
(
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic              op,
    input  logic [MOD_W-1:0]  q,
    output logic [DATA_W-1:0] res_c
);

    logic signed [TMP_W-1:0] acc_s;
    logic signed [TMP_W-1:0] opd_s;
    logic signed [TMP_W-1:0] q_s;
    logic signed [TMP_W-1:0] sum;
    logic signed [TMP_W-1:0] red;

    // Six signed bits cover the full -15..30 range of acc +/- operand.
    always_comb begin
        acc_s = $signed({2'b00, acc});
        opd_s = $signed({2'b00, operand});
        q_s   = $signed({q[MOD_W-1], q});
        sum   = (op == OP_SUB) ? (acc_s - opd_s) : (acc_s + opd_s);
        red   = sum;
        if (sum >= q_s) begin
            red = sum - q_s;
        end else if (sum[TMP_W-1]) begin
            red = sum + q_s;
        end
        res_c = red[DATA_W-1:0];
    end

endmodule

// File: rtl/mas_mod_accum.sv
// Burst modular accumulator: folds operands into a residue mod q, presents it on a handshake.
// Optional operand/modulus range checking: define MAS_MOD_ACCUM_RANGE_CHK_EN.
module mas_mod_accum
    import mas_mod_accum_pkg::*;
#(
    parameter int unsigned LEN_W = 3
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [MOD_W-1:0]  q,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              err
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic [MOD_W-1:0]  q_r;
    logic [MOD_W-1:0]  q_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              err_nxt;
    logic              hs;
    logic              q_bad;
    logic              opd_bad;
    operand_t          opd;
    logic [DATA_W-1:0] step_opd;
    logic [DATA_W-1:0] step_res_c;

    assign opd.op   = in_op;
    assign opd.data = in_data;
    assign hs       = in_valid && in_ready;

`ifdef MAS_MOD_ACCUM_RANGE_CHK_EN
    assign q_bad   = ($signed(q) < $signed(MOD_W'(2)));
    assign opd_bad = hs && ($signed({2'b00, opd.data}) >= $signed({q_r[MOD_W-1], q_r}));
`else
    assign q_bad   = 1'b0;
    assign opd_bad = 1'b0;
`endif

    // An out-of-range operand folds in as zero so the count still advances.
    assign step_opd = opd_bad ? DATA_W'(0) : opd.data;

    mas_mod_step u_step (
        .acc     (acc),
        .operand (step_opd),
        .op      (opd.op),
        .q       (q_r),
        .res_c   (step_res_c)
    );

    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        cnt_nxt      = cnt;
        q_nxt        = q_r;
        out_data_nxt = out_data;
        err_nxt      = err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACC;
                    q_nxt     = q;
                    acc_nxt   = DATA_W'(0);
                    cnt_nxt   = len;
                    err_nxt   = q_bad;
                end
            end
            ACC: begin
                if (hs) begin
                    acc_nxt = step_res_c;
                    if (opd_bad) begin
                        err_nxt = 1'b1;
                    end
                    if (cnt == LEN_W'(0)) begin
                        state_nxt    = DONE;
                        out_data_nxt = step_res_c;
                    end else begin
                        cnt_nxt = cnt - LEN_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake/status outputs are flopped from the next state so they track the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= DATA_W'(0);
            cnt       <= LEN_W'(0);
            q_r       <= MOD_W'(0);
            out_data  <= DATA_W'(0);
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            q_r       <= q_nxt;
            out_data  <= out_data_nxt;
            err       <= err_nxt;
            in_ready  <= (state_nxt == ACC);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_mas_mod_accum.sv
// Scoreboard bench for mas_mod_accum: directed bursts with hand-computed residues.
module tb_mas_mod_accum;
    import mas_mod_accum_pkg::*;

    localparam int unsigned LEN_W = 3;

    typedef struct {
        logic [3:0] data;
        logic       err;
        bit         chk;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [4:0]       q;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             in_op;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             busy;
    logic             err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mas_mod_accum #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .q         (q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic start_burst(input logic [4:0] qv, input logic [LEN_W-1:0] lv,
                               input logic [3:0] ed, input logic ee, input bit ec);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b1;
        q     = qv;
        len   = lv;
        e.data = ed;
        e.err  = ee;
        e.chk  = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input logic op);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        q         = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = OP_ADD;
        out_ready = 1'b1;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && out_valid) begin
                        if (sb.size() == 0) begin
                            check("sb_unexpected_result", out_valid, 0);
                        end else begin
                            e = sb[0];
                            if (e.chk) check("sb_out_data", out_data, e.data);
                            check("sb_err", err, e.err);
                            if (out_ready) e = sb.pop_front();
                        end
                    end
                end
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog timeout t=%0t", $time);
                $fatal(1, "bench timeout");
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        // Mixed burst: 7, 16->3, -2->11
        start_burst(5'd13, 3'd2, 4'd11, 1'b0, 1'b1);
        send(4'd7, OP_ADD);
        send(4'd9, OP_ADD);
        check("t1_no_early_valid", out_valid, 0);
        send(4'd5, OP_SUB);
        @(negedge clk);
        check("t1_valid_latency", out_valid, 1);

        // Back-pressure
        start_burst(5'd13, 3'd2, 4'd11, 1'b0, 1'b1);
        send(4'd7, OP_ADD);
        send(4'd9, OP_ADD);
        out_ready = 1'b0;
        send(4'd5, OP_SUB);
        repeat (5) begin
            @(negedge clk);
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_data", out_data, 11);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("t2_valid_before_accept", out_valid, 1);
        @(negedge clk);
        check("t2_idle_busy", busy, 0);
        check("t2_idle_valid", out_valid, 0);

        // Input stalls: 6,5,4,3
        start_burst(5'd7, 3'd3, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(4'd6, OP_ADD);
            if (i < 3) begin
                in_data = 4'd6;
                repeat (2) begin
                    @(negedge clk);
                    check("t3_gap_ready", in_ready, 1);
                    check("t3_gap_no_done", out_valid, 0);
                end
                @(posedge clk);
                #1;
            end
        end

        // Reset mid-burst, then fresh burst 0-4 -> 7
        start_burst(5'd11, 3'd7, 4'd0, 1'b0, 1'b1);
        send(4'd5, OP_ADD);
        send(4'd5, OP_ADD);
        send(4'd5, OP_ADD);
        rst_n = 1'b0;
        #2;
        check("t4_rst_in_ready", in_ready, 0);
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_out_data", out_data, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_err", err, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_burst(5'd11, 3'd0, 4'd7, 1'b0, 1'b1);
        send(4'd4, OP_SUB);
        @(negedge clk);
        check("t4_fresh_valid", out_valid, 1);

        // Ignored start during ACC and DONE
        start_burst(5'd13, 3'd2, 4'd11, 1'b0, 1'b1);
        send(4'd7, OP_ADD);
        start = 1'b1;
        q     = 5'd7;
        len   = 3'd0;
        @(posedge clk);
        #1 start = 1'b0;
        send(4'd9, OP_ADD);
        out_ready = 1'b0;
        send(4'd5, OP_SUB);
        @(negedge clk);
        check("t5_done_valid", out_valid, 1);
        @(posedge clk);
        #1;
        start    = 1'b1;
        q        = 5'd3;
        len      = 3'd5;
        in_valid = 1'b1;
        in_data  = 4'd1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_done_hold_valid", out_valid, 1);
        check("t5_done_hold_data", out_data, 11);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_back_idle", busy, 0);

        // Boundaries: top of range, smallest modulus, subtract wrap
        start_burst(5'd15, 3'd1, 4'd13, 1'b0, 1'b1);
        send(4'd14, OP_ADD);
        send(4'd14, OP_ADD);
        start_burst(5'd2, 3'd7, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send(4'd1, OP_ADD);
        start_burst(5'd9, 3'd1, 4'd1, 1'b0, 1'b1);
        send(4'd8, OP_SUB);
        send(4'd0, OP_SUB);

        // Range check
`ifdef MAS_MOD_ACCUM_RANGE_CHK_EN
        start_burst(5'd5, 3'd1, 4'd3, 1'b1, 1'b1);
`else
        start_burst(5'd5, 3'd1, 4'd0, 1'b0, 1'b0);
`endif
        send(4'd9, OP_ADD);
        send(4'd3, OP_ADD);
        @(negedge clk);
`ifdef MAS_MOD_ACCUM_RANGE_CHK_EN
        check("t7_err_set", err, 1);
        start_burst(5'd1, 3'd0, 4'd0, 1'b1, 1'b1);
        send(4'd0, OP_ADD);
`else
        check("t7_err_tied", err, 0);
`endif
        start_burst(5'd13, 3'd0, 4'd5, 1'b0, 1'b1);
        send(4'd5, OP_ADD);
        @(negedge clk);
        check("t7_err_cleared", err, 0);

        begin
            int n;
            n = 0;
            while (busy && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
